// File: rtl/elastic_pipe.sv
// elastic_pipe: STAGES-deep valid/ready register pipeline with bubble collapse,
// synchronous flush and an occupancy count. Stage 0 is the input side.
module elastic_pipe #(
    parameter int               WIDTH      = 8,
    parameter int               STAGES     = 2,
    parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          flush,
    output logic [$clog2(STAGES+1)-1:0]   count
);
    localparam int CW = $clog2(STAGES + 1);

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] w_stage_ready;
    logic [STAGES-1:0] w_up_valid;
    logic [WIDTH-1:0]  w_up_data [STAGES];
    logic [CW-1:0]     w_count;

    // Handshake: a side transfers on a rising edge exactly when its valid and
    // ready are both 1 on that edge; valid never depends on ready on either side,
    // and flush forces both in_ready and out_valid low so nothing moves.
    // A stage is ready when it or any stage downstream of it is empty, or the
    // consumer is taking the last item; written as a flat OR to avoid a comb loop.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_stage_ready[k] = out_ready;
            for (int j = k; j < STAGES; j++) begin
                if (!r_valid[j]) begin
                    w_stage_ready[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_up_valid[0] = in_valid;
        w_up_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            w_up_valid[k] = r_valid[k-1];
            w_up_data[k]  = r_data[k-1];
        end
    end

    always_comb begin
        w_count = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_count = w_count + CW'(r_valid[k]);
        end
    end

    // Data registers only capture real items; empty stages keep stale data hidden by valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= RESET_DATA;
            end
        end else if (flush) begin
            r_valid <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_stage_ready[k]) begin
                    r_valid[k] <= w_up_valid[k];
                    if (w_up_valid[k]) begin
                        r_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    end

    assign in_ready  = w_stage_ready[0] && !flush;
    assign out_valid = r_valid[STAGES-1] && !flush;
    assign out_data  = r_data[STAGES-1];
    assign count     = w_count;

endmodule

// File: tb/tb_elastic_pipe.sv
// Bench for elastic_pipe: four instances (STAGES 1..4) share one stimulus stream and are
// each compared every cycle against a queue-of-positions model, plus directed literal checks.
module tb_elastic_pipe;

    typedef struct {
        logic [7:0] d;
        int         pos;
    } item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;
    logic       flush;

    logic       ir_a  [4];
    logic       ov_a  [4];
    logic [7:0] od_a  [4];
    logic [2:0] cnt_a [4];

    logic [7:0] log1 [$];
    logic [7:0] log2 [$];
    logic [7:0] log3 [$];

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s [STAGES=%0d] t=%0t: got %0h expected %0h", nm, inst + 1, $time, act, exp);
        end
    endtask

    // ---------------- DUTs, models, per-cycle compare ----------------
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int         S  = g + 1;
        localparam logic [7:0] RD = (g == 2) ? 8'hFF : 8'h00;

        logic [$clog2(S+1)-1:0] cnt;
        item_t mq [$];
        int    sz;
        int    lim;
        int    np;
        bit    acc;

        elastic_pipe #(.WIDTH(8), .STAGES(S), .RESET_DATA(RD)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (ir_a[g]),
            .in_data   (in_data),
            .out_valid (ov_a[g]),
            .out_ready (out_ready),
            .out_data  (od_a[g]),
            .flush     (flush),
            .count     (cnt)
        );

        assign cnt_a[g] = 3'(cnt);

        // Model: list of items oldest-first with their stage position; each item
        // advances one stage per edge unless blocked by the item ahead of it.
        initial begin
            forever begin
                @(posedge clk or posedge reset);
                if (reset) begin
                    mq.delete();
                end else if (flush) begin
                    mq.delete();
                end else begin
                    sz  = mq.size();
                    acc = in_valid && (sz < S || out_ready);
                    if (sz > 0) begin
                        if (mq[0].pos == S - 1 && out_ready) begin
                            void'(mq.pop_front());
                        end
                    end
                    lim = S - 1;
                    for (int i = 0; i < mq.size(); i++) begin
                        np = mq[i].pos + 1;
                        if (np > lim) np = lim;
                        mq[i].pos = np;
                        lim = np - 1;
                    end
                    if (acc) begin
                        mq.push_back('{d: in_data, pos: 0});
                    end
                end
            end
        end

        always @(negedge clk) begin
            logic       e_ready;
            logic       e_valid;
            logic [7:0] e_data;
            e_ready = !flush && (mq.size() < S || out_ready);
            e_valid = 1'b0;
            e_data  = 8'h00;
            if (mq.size() > 0) begin
                e_valid = !flush && (mq[0].pos == S - 1);
                e_data  = mq[0].d;
            end
            chk("in_ready", g, 32'(ir_a[g]), 32'(e_ready));
            chk("out_valid", g, 32'(ov_a[g]), 32'(e_valid));
            chk("count", g, 32'(cnt_a[g]), 32'(mq.size()));
            if (e_valid) begin
                chk("out_data", g, 32'(od_a[g]), 32'(e_data));
            end
        end
    end

    // Output transfer logs used by the directed ordering checks.
    always @(negedge clk) begin
        if (ov_a[1] && out_ready) log1.push_back(od_a[1]);
        if (ov_a[2] && out_ready) log2.push_back(od_a[2]);
        if (ov_a[3] && out_ready) log3.push_back(od_a[3]);
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) cyc();
    endtask

    // Unstalled stream into an empty pipe; pins latency for STAGES=3 and STAGES=1.
    task automatic stream(input logic [7:0] base, input int n);
        logic [7:0] e;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            #2;
            chk("stream_in_ready", 2, 32'(ir_a[2]), 32'd1);
            chk("stream_valid3", 2, 32'(ov_a[2]), (i >= 3) ? 32'd1 : 32'd0);
            chk("stream_count3", 2, 32'(cnt_a[2]), (i >= 3) ? 32'd3 : 32'(i));
            if (i >= 3) begin
                e = base + 8'(i - 3);
                chk("stream_data3", 2, 32'(od_a[2]), 32'(e));
            end
            chk("s1_in_ready", 0, 32'(ir_a[0]), 32'd1);
            if (i >= 1) begin
                e = base + 8'(i - 1);
                chk("s1_data", 0, 32'(od_a[0]), 32'(e));
            end
            cyc();
        end
        in_valid = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] exp_bp [5];
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        flush     = 1'b0;
        cyc();
        #2;
        chk("rst_out_valid", 2, 32'(ov_a[2]), 32'd0);
        chk("rst_out_data", 2, 32'(od_a[2]), 32'hFF);
        chk("rst_count", 2, 32'(cnt_a[2]), 32'd0);
        chk("rst_in_ready", 2, 32'(ir_a[2]), 32'd1);
        chk("rst_out_data_s1", 0, 32'(od_a[0]), 32'h00);
        cyc();
        reset = 1'b0;

        stream(8'h01, 10);

        // Backpressure on a full 3-stage pipe, producer holds 0x13/0x14 until taken.
        drain();
        out_ready = 1'b0;
        log2.delete();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h10 + 8'(i);
            #2;
            chk("bp_accept", 2, 32'(ir_a[2]), 32'd1);
            cyc();
        end
        in_data = 8'h13;
        #2;
        chk("bp_stall_in_ready", 2, 32'(ir_a[2]), 32'd0);
        chk("bp_full_count", 2, 32'(cnt_a[2]), 32'd3);
        cyc();
        #2;
        chk("bp_stall_hold", 2, 32'(ir_a[2]), 32'd0);
        chk("bp_data_stable", 2, 32'(od_a[2]), 32'h10);
        cyc();
        out_ready = 1'b1;
        #2;
        chk("bp_release_in_ready", 2, 32'(ir_a[2]), 32'd1);
        cyc();
        in_data = 8'h14;
        #2;
        chk("bp_accept_last", 2, 32'(ir_a[2]), 32'd1);
        cyc();
        in_valid = 1'b0;
        repeat (6) cyc();
        exp_bp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk("bp_out_count", 2, 32'(log2.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < log2.size()) chk("bp_out_order", 2, 32'(log2[i]), 32'(exp_bp[i]));
        end

        // Bubble collapse in the 4-stage pipe.
        drain();
        out_ready = 1'b0;
        log3.delete();
        in_valid = 1'b1;
        in_data  = 8'hAA;
        #2;
        chk("bub_accept_aa", 3, 32'(ir_a[3]), 32'd1);
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        #2;
        chk("bub_aa_at_out", 3, 32'(ov_a[3]), 32'd1);
        chk("bub_count1", 3, 32'(cnt_a[3]), 32'd1);
        in_valid = 1'b1;
        in_data  = 8'hBB;
        #2;
        chk("bub_accept_bb", 3, 32'(ir_a[3]), 32'd1);
        cyc();
        in_valid = 1'b0;
        cyc();
        in_valid = 1'b1;
        in_data  = 8'hCC;
        #2;
        chk("bub_accept_cc", 3, 32'(ir_a[3]), 32'd1);
        cyc();
        in_valid = 1'b0;
        #2;
        chk("bub_count3", 3, 32'(cnt_a[3]), 32'd3);
        out_ready = 1'b1;
        repeat (6) cyc();
        chk("bub_out_count", 3, 32'(log3.size()), 32'd3);
        if (log3.size() == 3) begin
            chk("bub_order0", 3, 32'(log3[0]), 32'hAA);
            chk("bub_order1", 3, 32'(log3[1]), 32'hBB);
            chk("bub_order2", 3, 32'(log3[2]), 32'hCC);
        end

        // Flush a full 2-stage pipe while an input is offered.
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h21;
        cyc();
        in_data = 8'h22;
        cyc();
        log1.delete();
        in_data   = 8'h55;
        flush     = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("fl_in_ready", 1, 32'(ir_a[1]), 32'd0);
        chk("fl_out_valid", 1, 32'(ov_a[1]), 32'd0);
        chk("fl_count_same_cycle", 1, 32'(cnt_a[1]), 32'd2);
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        #2;
        chk("fl_count_after", 1, 32'(cnt_a[1]), 32'd0);
        chk("fl_valid_after", 1, 32'(ov_a[1]), 32'd0);
        repeat (4) cyc();
        chk("fl_nothing_out", 1, 32'(log1.size()), 32'd0);

        // Asynchronous reset between edges with two items inside.
        drain();
        in_valid = 1'b1;
        in_data  = 8'h31;
        cyc();
        in_data = 8'h32;
        cyc();
        in_valid = 1'b0;
        #2;
        chk("ar_count_before", 2, 32'(cnt_a[2]), 32'd2);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_out_valid", 2, 32'(ov_a[2]), 32'd0);
        chk("ar_out_data", 2, 32'(od_a[2]), 32'hFF);
        chk("ar_count", 2, 32'(cnt_a[2]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        stream(8'h41, 6);

        // Randomised traffic checked by the per-cycle models.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #3;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end else begin
                cyc();
            end
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/elastic_pipe.md
# elastic_pipe

Parametrised, back-pressurable register pipeline that generalises the single delayed output register (`q <= #(REG_DELAY*2) d`) into an N-stage elastic delay line. It carries a WIDTH-bit payload with valid/ready handshaking on both sides, collapses bubbles, supports a synchronous flush, and reports occupancy. It sits between any producer/consumer pair that needs fixed latency plus tolerance of downstream stalls.

## Interface
- WIDTH, 8, payload width in bits (≥1)
- STAGES, 2, number of register stages (1..16); unstalled latency in cycles
- RESET_DATA, 0, value loaded into every data register on reset (WIDTH bits)
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers in_data
- in_ready  output  1  pipe accepts in_data this cycle
- in_data  input  WIDTH  payload in
- out_valid  output  1  last stage holds a valid item
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  WIDTH  payload out (last-stage data register)
- flush  input  1  synchronous discard of all contents
- count  output  $clog2(STAGES+1)  number of valid stages

## Operation
- Stage k (0 = input side, STAGES-1 = output side) holds v[k] and d[k].
- Stage ready: r[STAGES-1] = !v[STAGES-1] || out_ready; r[k] = !v[k] || r[k+1] for k < STAGES-1. The chain is combinational, with no registered skid.
- in_ready = r[0] && !flush. out_valid = v[STAGES-1] && !flush. out_data = d[STAGES-1].
- Transfers:
  - Input transfer = in_valid && in_ready.
  - Output transfer = out_valid && out_ready.
  - While flush = 1, no transfers occur in either direction.
- Per-edge update when flush = 0:
  - If r[k] = 1, stage k loads from its upstream: from the input for k = 0, otherwise from stage k-1.
  - Stage 0 loads v = in_valid and d = in_data.
  - Stage k loads v = v[k-1] and d = d[k-1].
  - If r[k] = 0, stage k holds.
- Data registers load only when the upstream valid is 1. Empty stages keep stale data. Stale data is never observable, because out_valid gates it.
- Flush: on the edge where flush = 1, all v[k] clear. d[k] is unchanged.
- count = popcount(v). It is purely a function of the registered valid bits and does not depend on flush in the same cycle.
- Ordering: items exit in acceptance order. No item is ever lost, duplicated or reordered except by flush/reset.
- STAGES = 1: single register with pass-through ready. When full and out_ready = 1, it emits and accepts on the same edge.

## Timing
- Reset (asynchronous): effective immediately, independent of clk.
  - All v[k] = 0 and all d[k] = RESET_DATA.
  - Hence out_valid = 0, out_data = RESET_DATA, count = 0.
  - in_ready = 1 (unless flush = 1).
- Reset deassertion: the first active edge after deassertion may accept data.
- Latency:
  - An item accepted at edge T, with no stalls, is presented on out_valid/out_data after edge T+STAGES-1.
  - It transfers out at edge T+STAGES.
  - Equivalently, it is visible STAGES cycles after it was offered.
- Throughput: one item per cycle sustained when out_ready = 1.
- Stall: out_ready = 0 with a full pipe (count = STAGES) gives in_ready = 0 in the same cycle.
- Partial fill under stall: bubbles collapse. in_ready stays 1 until all STAGES are valid.
- Release after stall: when out_ready rises with a full pipe, in_ready rises in the same cycle (combinational). The pipe shifts and accepts on that edge.
- Simultaneous flush and in_valid: the input is dropped and in_ready = 0. The next-cycle count is 0.
- Simultaneous flush and out_ready: no output transfer. out_valid reads 0 during the flush cycle.
- out_data is stable while out_valid && !out_ready.
- count changes only on clk edges or on reset.

## Test plan
- Stream, STAGES = 3, WIDTH = 8, out_ready = 1: offer 0x01..0x0A on consecutive cycles → 0x01 becomes visible 3 cycles after it is offered; then one item per cycle through 0x0A; count holds at 3 during steady state; in_ready is never 0.
- Backpressure, STAGES = 3: out_ready = 0 while offering 0x10..0x14 → 0x10..0x12 accepted, in_ready = 0, count = 3. Then out_ready = 1 → output 0x10..0x14 in order, with no loss or duplicate.
- Bubble collapse, STAGES = 4: one item 0xAA reaches the last stage with out_ready = 0, then offer 0xBB and 0xCC two cycles apart → both accepted, count = 3. Release → output order AA, BB, CC.
- Flush with full pipe, STAGES = 2, and in_valid = 1 with data 0x55 during flush → in_ready = 0, out_valid = 0 in the flush cycle; count = 0 next cycle; 0x55 never appears at the output.
- Asynchronous reset mid-stream, STAGES = 3, RESET_DATA = 0xFF: assert reset between clock edges with count = 2 → out_valid = 0, out_data = 0xFF, count = 0 immediately. After release, a new stream flows with normal latency.
- STAGES = 1, out_ready = 1, in_valid held at 1 with an incrementing value → in_ready = 1 every cycle, and out_data follows in_data by 1 cycle.
